// File: rtl/hive_irq_ctl_pkg.sv
// Shared sizes, rbus address and thread-id types for the hive interrupt controller.
// Build option: HIVE_IRQ_SYNC_EN (see hive_irq_ctl.sv).
`ifndef RBUS_IRQ
`define RBUS_IRQ 8'h24
`endif

package hive_irq_ctl_pkg;

  localparam int unsigned HIVE_THREADS     = 8;
  localparam int unsigned HIVE_ALU_W       = 32;
  localparam int unsigned HIVE_RBUS_ADDR_W = 8;
  localparam int unsigned HIVE_TID_W       = $clog2(HIVE_THREADS);

  localparam logic [HIVE_RBUS_ADDR_W-1:0] RBUS_IRQ_ADDR = `RBUS_IRQ;

  // Only the stage-0 slot id is routed to this block.
  localparam int unsigned HIVE_PIPE_STAGES = 1;

  typedef logic [HIVE_TID_W-1:0] tid_t;
  typedef tid_t [HIVE_PIPE_STAGES-1:0] ID_T;

endpackage

// File: rtl/hive_reg_base.sv
// Single rbus register slot: one R/W field stored here, an optional write-1-to-clear
// field exported as a pulse, and registered read data taken from a loop-back word.
module hive_reg_base #(
  parameter int unsigned       ADDR_W  = 8,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [ADDR_W-1:0] ADDR    = '0,
  parameter                    WR_MODE = "COW1",
  parameter                    RD_MODE = "LOOP",
  parameter int unsigned       RW_W    = 8,
  parameter int unsigned       CLR_LSB = 8,
  parameter int unsigned       CLR_W   = 8,
  parameter logic [DATA_W-1:0] RD_MASK = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] loop,
  output logic [DATA_W-1:0] rd_data,
  output logic [RW_W-1:0]   rw_q,
  output logic [CLR_W-1:0]  clr
);

  logic              hit_wr;
  logic              hit_rd;
  logic [DATA_W-1:0] rd_src;

  assign hit_wr = wr && (addr == ADDR);
  assign hit_rd = rd && (addr == ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rw_q <= '0;
    end else if (hit_wr) begin
      rw_q <= RW_W'(wr_data);
    end
  end

  generate
    if (WR_MODE == "COW1") begin : g_cow1
      assign clr = hit_wr ? CLR_W'(wr_data >> CLR_LSB) : '0;
    end else begin : g_rw
      assign clr = '0;
    end

    if (RD_MODE == "LOOP") begin : g_loop
      assign rd_src = loop;
    end else begin : g_self
      assign rd_src = DATA_W'(rw_q);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (hit_rd) begin
      rd_data <= rd_src & RD_MASK;
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/hive_irq_ctl.sv
// Per-thread interrupt controller: edge detect, pending/in-service tracking, slot issue.
// Build option HIVE_IRQ_SYNC_EN inserts a 2-flop synchronizer ahead of the edge detect.
//
// Per-thread state (pend, ise):
//   state      | meaning
//   idle  0,0  | nothing outstanding
//   pend  1,0  | waiting for the thread's slot
//   serv  0,1  | handler running, waiting for irt
//   both  1,1  | handler running, next irq queued
module hive_irq_ctl
  import hive_irq_ctl_pkg::*;
#(
  parameter int unsigned            THREADS     = HIVE_THREADS,
  parameter int unsigned            ALU_W       = HIVE_ALU_W,
  parameter int unsigned            RBUS_ADDR_W = HIVE_RBUS_ADDR_W,
  parameter logic [RBUS_ADDR_W-1:0] ADDR        = `RBUS_IRQ
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [RBUS_ADDR_W-1:0] rbus_addr_i,
  input  logic                   rbus_wr_i,
  input  logic                   rbus_rd_i,
  input  logic [ALU_W-1:0]       rbus_wr_data_i,
  output logic [ALU_W-1:0]       rbus_rd_data_o,
  input  logic [THREADS-1:0]     irq_i,
  input  ID_T                    id_i,
  input  logic                   irt_i,
  output logic                   irq_o,
  output logic [THREADS-1:0]     irq_er_o
);

  localparam logic [ALU_W-1:0] RD_MASK = ~({ALU_W{1'b1}} << (3 * THREADS));

  logic [THREADS-1:0] irq_src;
  logic [THREADS-1:0] irq_q;
  logic [THREADS-1:0] en;
  logic [THREADS-1:0] pend;
  logic [THREADS-1:0] ise;
  logic [THREADS-1:0] clr;
  logic [THREADS-1:0] rise;
  logic [THREADS-1:0] hit;
  logic [THREADS-1:0] issue_vec;
  logic [THREADS-1:0] pend_nx;
  logic [THREADS-1:0] ise_nx;
  logic [THREADS-1:0] err_nx;
  logic [ALU_W-1:0]   status;
  tid_t               sel;

`ifdef HIVE_IRQ_SYNC_EN
  localparam int unsigned ARM_W = 3;
  logic [THREADS-1:0] sync_a;
  logic [THREADS-1:0] sync_b;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= irq_i;
      sync_b <= sync_a;
    end
  end

  assign irq_src = sync_b;
`else
  localparam int unsigned ARM_W = 1;
  assign irq_src = irq_i;
`endif

  // Edge detection stays disarmed until irq_q has captured the post-reset line level,
  // so a line already high when reset releases is not mistaken for a new request.
  logic [ARM_W-1:0] arm_sr;
  logic             armed;
  assign armed = arm_sr[ARM_W-1];

  assign sel = id_i[0];

  hive_reg_base #(
    .ADDR_W  (RBUS_ADDR_W),
    .DATA_W  (ALU_W),
    .ADDR    (ADDR),
    .WR_MODE ("COW1"),
    .RD_MODE ("LOOP"),
    .RW_W    (THREADS),
    .CLR_LSB (THREADS),
    .CLR_W   (THREADS),
    .RD_MASK (RD_MASK)
  ) u_reg (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .addr    (rbus_addr_i),
    .wr      (rbus_wr_i),
    .rd      (rbus_rd_i),
    .wr_data (rbus_wr_data_i),
    .loop    (status),
    .rd_data (rbus_rd_data_o),
    .rw_q    (en),
    .clr     (clr)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      irq_q    <= '0;
      pend     <= '0;
      ise      <= '0;
      irq_er_o <= '0;
      arm_sr   <= '0;
    end else begin
      irq_q    <= irq_src;
      pend     <= pend_nx;
      ise      <= ise_nx;
      irq_er_o <= err_nx;
      arm_sr   <= (arm_sr << 1) | ARM_W'(1);
    end
  end

  always_comb begin
    rise           = irq_src & ~irq_q & {THREADS{armed}};
    hit            = rise & en;
    issue_vec      = '0;
    issue_vec[sel] = pend[sel] & en[sel] & ~ise[sel] & ~clr[sel];
    err_nx         = hit & (ise | pend);
    // A new edge outranks both the issue clear and an rbus clear of pend.
    pend_nx        = (pend & ~issue_vec & ~clr) | hit;
    ise_nx         = ise | issue_vec;
    if (irt_i && ise[sel]) begin
      ise_nx[sel] = 1'b0;
    end
  end

  always_comb begin
    irq_o                   = |issue_vec;
    status                  = '0;
    status[3*THREADS-1:0]   = {ise, pend, en};
  end

endmodule
